// File: rtl/alu_mc_if.sv
// Operand/result bundle between the multicycle control path and alu_mc.
interface alu_mc_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               i_start;
    logic [5:0]         i_op;
    logic [SHAMT_W-1:0] i_shamt;
    logic [WIDTH-1:0]   i_a;
    logic [WIDTH-1:0]   i_b;
    logic [WIDTH-1:0]   o_result;
    logic               o_busy;
    logic               o_done;
    logic               o_zero;

    modport master (
        output i_start, i_op, i_shamt, i_a, i_b,
        input  o_result, o_busy, o_done, o_zero
    );

    modport slave (
        input  i_start, i_op, i_shamt, i_a, i_b,
        output o_result, o_busy, o_done, o_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle R-type ops plus an iterative shift-add 16x16 multiply.
// Single ops finish in 1 edge; mult16 in MUL_W+1 edges; start is ignored while busy.
module alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int MUL_W   = 16
) (
    input  logic  i_clk,
    input  logic  i_rst,
    alu_mc_if.slave bus
);
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam int         CNT_W   = $clog2(MUL_W) + 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             r_state;
    logic [2*MUL_W-1:0] r_mcand;
    logic [2*MUL_W-1:0] r_acc;
    logic [MUL_W-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_alu;
    logic [2*MUL_W-1:0] w_acc_next;

    always_comb begin
        w_alu = '0;
        case (bus.i_op)
            OP_ADD: w_alu = bus.i_a + bus.i_b;
            OP_SUB: w_alu = bus.i_a - bus.i_b;
            OP_AND: w_alu = bus.i_a & bus.i_b;
            OP_OR:  w_alu = bus.i_a | bus.i_b;
            OP_XOR: w_alu = bus.i_a ^ bus.i_b;
            OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
            OP_SLL: w_alu = bus.i_b << bus.i_shamt;
            OP_SRL: w_alu = bus.i_b >> bus.i_shamt;
            OP_SRA: w_alu = WIDTH'($signed(bus.i_b) >>> bus.i_shamt);
            default: w_alu = '0;
        endcase
    end

    // Final accumulate step is folded into the completion edge.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_op == OP_MULT) begin
                            r_mcand  <= {{MUL_W{1'b0}}, bus.i_a[MUL_W-1:0]};
                            r_mplier <= bus.i_b[MUL_W-1:0];
                            r_acc    <= '0;
                            r_count  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            r_result <= w_alu;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == CNT_W'(MUL_W - 1)) begin
                        r_result <= WIDTH'(w_acc_next);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_zero   = (r_result == '0);
endmodule
